// File: rtl/cpu_cache_dm_if.sv
// cpu_cache_dm_if: CPU-side request/response and backing-memory signals for the cache.
interface cpu_cache_dm_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              rd_en;
    logic              wr_en;
    logic              flush;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] out_data;
    logic              rd_valid;
    logic              busy;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic [15:0]       hit_cnt;
    logic [15:0]       miss_cnt;

    modport slave (
        input  rd_en, wr_en, flush, addr, data, mem_ack, mem_rdata,
        output out_data, rd_valid, busy, mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt
    );
    modport master (
        output rd_en, wr_en, flush, addr, data, mem_ack, mem_rdata,
        input  out_data, rd_valid, busy, mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/cpu_cache_dm.sv
// cpu_cache_dm: direct-mapped, one-word-per-line, write-through no-allocate cache
// with a request/acknowledge backing-memory port and saturating hit/miss counters.
module cpu_cache_dm #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int IDX_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    cpu_cache_dm_if.slave        bus
);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam int LINES = 2 ** IDX_W;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] MEM_RD = 2'd1;
    localparam logic [1:0] MEM_WR = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [1:0]        r_state;
    logic              r_busy;
    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [DATA_W-1:0] r_data [LINES];
    logic [DATA_W-1:0] r_out_data;
    logic              r_rd_valid;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [15:0]       r_hit_cnt;
    logic [15:0]       r_miss_cnt;

    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic              w_hit;
    logic [IDX_W-1:0]  w_fidx;
    logic              w_fill;
    logic              w_wr_hit;

    assign w_idx    = bus.addr[IDX_W-1:0];
    assign w_tag    = bus.addr[ADDR_W-1:IDX_W];
    assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_fidx   = r_mem_addr[IDX_W-1:0];
    assign w_fill   = (r_state == MEM_RD) && bus.mem_ack;
    assign w_wr_hit = (r_state == IDLE) && !bus.flush && bus.wr_en && w_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_valid     <= '0;
            r_out_data  <= '0;
            r_rd_valid  <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
        end else begin
            r_rd_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.flush) begin
                        r_valid <= '0;
                    end else if (bus.wr_en) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= bus.addr;
                        r_mem_wdata <= bus.data;
                        r_state     <= MEM_WR;
                        r_busy      <= 1'b1;
                    end else if (bus.rd_en && w_hit) begin
                        r_rd_valid <= 1'b1;
                        r_out_data <= r_data[w_idx];
                        r_hit_cnt  <= (r_hit_cnt == 16'hFFFF) ? r_hit_cnt : r_hit_cnt + 16'd1;
                    end else if (bus.rd_en) begin
                        r_miss_cnt <= (r_miss_cnt == 16'hFFFF) ? r_miss_cnt : r_miss_cnt + 16'd1;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= bus.addr;
                        r_state    <= MEM_RD;
                        r_busy     <= 1'b1;
                    end
                end
                MEM_RD: begin
                    if (bus.mem_ack) begin
                        r_valid[w_fidx] <= 1'b1;
                        r_out_data      <= bus.mem_rdata;
                        r_rd_valid      <= 1'b1;
                        r_mem_req       <= 1'b0;
                        r_state         <= RESP;
                    end
                end
                MEM_WR: begin
                    if (bus.mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_state   <= IDLE;
                        r_busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Tags and data carry no reset; the valid bits alone decide residency.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_fidx]  <= r_mem_addr[ADDR_W-1:IDX_W];
            r_data[w_fidx] <= bus.mem_rdata;
        end else if (w_wr_hit) begin
            r_data[w_idx] <= bus.data;
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.busy      = r_busy;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.hit_cnt   = r_hit_cnt;
    assign bus.miss_cnt  = r_miss_cnt;
endmodule

// File: tb/tb_cpu_cache_dm.sv
// tb_cpu_cache_dm: directed scenario tests for cpu_cache_dm with hand-computed expectations.
module tb_cpu_cache_dm;
    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    cpu_cache_dm_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    cpu_cache_dm #(.ADDR_W(8), .DATA_W(8), .IDX_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_rd(input logic [7:0] a);
        bus.rd_en = 1'b1;
        bus.addr  = a;
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic do_wr(input logic [7:0] a, input logic [7:0] d);
        bus.wr_en = 1'b1;
        bus.addr  = a;
        bus.data  = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic do_ack(input logic [7:0] d);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = d;
        tick();
        bus.mem_ack   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.rd_en = 0; bus.wr_en = 0; bus.flush = 0; bus.addr = 0; bus.data = 0;
        bus.mem_ack = 0; bus.mem_rdata = 0;
        tick();
        tick();
        n_total++;
        if ({bus.busy, bus.rd_valid, bus.mem_req, bus.mem_we} !== 4'b0)
            $display("FAIL reset_ctrl got %b want 0000", {bus.busy, bus.rd_valid, bus.mem_req, bus.mem_we});
        else n_pass++;
        n_total++;
        if ({bus.out_data, bus.mem_addr, bus.mem_wdata, bus.hit_cnt, bus.miss_cnt} !== 56'h0)
            $display("FAIL reset_vals got %h want 0", {bus.out_data, bus.mem_addr, bus.mem_wdata, bus.hit_cnt, bus.miss_cnt});
        else n_pass++;
        #2 rst = 1'b1;
        tick();
    endtask

    task automatic test_read_miss();
        do_rd(8'h05);
        n_total++;
        if ({bus.busy, bus.mem_req, bus.mem_we, bus.mem_addr, bus.miss_cnt, bus.rd_valid} !== {1'b1, 1'b1, 1'b0, 8'h05, 16'd1, 1'b0})
            $display("FAIL miss_req got busy=%b req=%b we=%b addr=%h miss=%0d rv=%b want 1 1 0 05 1 0",
                     bus.busy, bus.mem_req, bus.mem_we, bus.mem_addr, bus.miss_cnt, bus.rd_valid);
        else n_pass++;
        tick();
        n_total++;
        if ({bus.mem_req, bus.mem_addr} !== {1'b1, 8'h05})
            $display("FAIL miss_hold got req=%b addr=%h want 1 05", bus.mem_req, bus.mem_addr);
        else n_pass++;
        do_ack(8'hA5);
        n_total++;
        if ({bus.rd_valid, bus.out_data, bus.mem_req, bus.busy} !== {1'b1, 8'hA5, 1'b0, 1'b1})
            $display("FAIL miss_resp got rv=%b data=%h req=%b busy=%b want 1 a5 0 1",
                     bus.rd_valid, bus.out_data, bus.mem_req, bus.busy);
        else n_pass++;
        tick();
        n_total++;
        if ({bus.rd_valid, bus.busy, bus.out_data} !== {1'b0, 1'b0, 8'hA5})
            $display("FAIL miss_done got rv=%b busy=%b data=%h want 0 0 a5", bus.rd_valid, bus.busy, bus.out_data);
        else n_pass++;
    endtask

    task automatic test_read_hit();
        bus.rd_en = 1'b1;
        bus.addr  = 8'h05;
        tick();
        n_total++;
        if ({bus.rd_valid, bus.out_data, bus.hit_cnt, bus.mem_req, bus.busy} !== {1'b1, 8'hA5, 16'd1, 1'b0, 1'b0})
            $display("FAIL hit_first got rv=%b data=%h hit=%0d req=%b busy=%b want 1 a5 1 0 0",
                     bus.rd_valid, bus.out_data, bus.hit_cnt, bus.mem_req, bus.busy);
        else n_pass++;
        tick();
        bus.rd_en = 1'b0;
        n_total++;
        if ({bus.rd_valid, bus.hit_cnt} !== {1'b1, 16'd2})
            $display("FAIL hit_b2b got rv=%b hit=%0d want 1 2", bus.rd_valid, bus.hit_cnt);
        else n_pass++;
        tick();
        n_total++;
        if ({bus.rd_valid, bus.out_data, bus.miss_cnt} !== {1'b0, 8'hA5, 16'd1})
            $display("FAIL hit_end got rv=%b data=%h miss=%0d want 0 a5 1", bus.rd_valid, bus.out_data, bus.miss_cnt);
        else n_pass++;
    endtask

    task automatic test_write();
        do_wr(8'h05, 8'h3C);
        n_total++;
        if ({bus.busy, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {3'b111, 8'h05, 8'h3C})
            $display("FAIL wr_req got busy=%b req=%b we=%b addr=%h wd=%h want 1 1 1 05 3c",
                     bus.busy, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        else n_pass++;
        tick();
        do_ack(8'h00);
        n_total++;
        if ({bus.busy, bus.mem_req, bus.rd_valid, bus.hit_cnt, bus.miss_cnt} !== {3'b000, 16'd2, 16'd1})
            $display("FAIL wr_done got busy=%b req=%b rv=%b hit=%0d miss=%0d want 0 0 0 2 1",
                     bus.busy, bus.mem_req, bus.rd_valid, bus.hit_cnt, bus.miss_cnt);
        else n_pass++;
        do_rd(8'h05);
        n_total++;
        if ({bus.rd_valid, bus.out_data, bus.hit_cnt} !== {1'b1, 8'h3C, 16'd3})
            $display("FAIL wr_hit_rd got rv=%b data=%h hit=%0d want 1 3c 3", bus.rd_valid, bus.out_data, bus.hit_cnt);
        else n_pass++;
        do_wr(8'h09, 8'h55);
        do_ack(8'h00);
        do_rd(8'h05);
        n_total++;
        if ({bus.rd_valid, bus.out_data, bus.hit_cnt, bus.miss_cnt} !== {1'b1, 8'h3C, 16'd4, 16'd1})
            $display("FAIL wr_miss_keep got rv=%b data=%h hit=%0d miss=%0d want 1 3c 4 1",
                     bus.rd_valid, bus.out_data, bus.hit_cnt, bus.miss_cnt);
        else n_pass++;
    endtask

    task automatic test_alias();
        do_rd(8'h09);
        n_total++;
        if ({bus.mem_req, bus.mem_addr, bus.miss_cnt} !== {1'b1, 8'h09, 16'd2})
            $display("FAIL alias_miss got req=%b addr=%h miss=%0d want 1 09 2", bus.mem_req, bus.mem_addr, bus.miss_cnt);
        else n_pass++;
        do_ack(8'h77);
        n_total++;
        if ({bus.rd_valid, bus.out_data} !== {1'b1, 8'h77})
            $display("FAIL alias_fill got rv=%b data=%h want 1 77", bus.rd_valid, bus.out_data);
        else n_pass++;
        tick();
        do_rd(8'h09);
        n_total++;
        if ({bus.rd_valid, bus.out_data, bus.hit_cnt} !== {1'b1, 8'h77, 16'd5})
            $display("FAIL alias_hit got rv=%b data=%h hit=%0d want 1 77 5", bus.rd_valid, bus.out_data, bus.hit_cnt);
        else n_pass++;
        do_rd(8'h05);
        n_total++;
        if ({bus.mem_req, bus.rd_valid, bus.miss_cnt} !== {1'b1, 1'b0, 16'd3})
            $display("FAIL alias_evict got req=%b rv=%b miss=%0d want 1 0 3", bus.mem_req, bus.rd_valid, bus.miss_cnt);
        else n_pass++;
        do_ack(8'h3C);
        tick();
    endtask

    task automatic test_flush();
        bus.flush = 1'b1;
        bus.rd_en = 1'b1;
        bus.addr  = 8'h05;
        tick();
        bus.flush = 1'b0;
        bus.rd_en = 1'b0;
        n_total++;
        if ({bus.busy, bus.mem_req, bus.rd_valid, bus.hit_cnt, bus.miss_cnt} !== {3'b000, 16'd5, 16'd3})
            $display("FAIL flush_quiet got busy=%b req=%b rv=%b hit=%0d miss=%0d want 0 0 0 5 3",
                     bus.busy, bus.mem_req, bus.rd_valid, bus.hit_cnt, bus.miss_cnt);
        else n_pass++;
        do_rd(8'h05);
        n_total++;
        if ({bus.mem_req, bus.rd_valid, bus.miss_cnt} !== {1'b1, 1'b0, 16'd4})
            $display("FAIL flush_miss got req=%b rv=%b miss=%0d want 1 0 4", bus.mem_req, bus.rd_valid, bus.miss_cnt);
        else n_pass++;
        do_ack(8'h3C);
        tick();
    endtask

    task automatic test_priority_busy();
        bus.rd_en = 1'b1;
        do_wr(8'h06, 8'h11);
        bus.rd_en = 1'b0;
        n_total++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.miss_cnt} !== {2'b11, 8'h06, 8'h11, 16'd4})
            $display("FAIL prio_wr got req=%b we=%b addr=%h wd=%h miss=%0d want 1 1 06 11 4",
                     bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.miss_cnt);
        else n_pass++;
        do_rd(8'h05);
        do_wr(8'h0A, 8'hEE);
        n_total++;
        if ({bus.rd_valid, bus.hit_cnt, bus.mem_addr, bus.mem_wdata, bus.busy} !== {1'b0, 16'd5, 8'h06, 8'h11, 1'b1})
            $display("FAIL busy_ignore got rv=%b hit=%0d addr=%h wd=%h busy=%b want 0 5 06 11 1",
                     bus.rd_valid, bus.hit_cnt, bus.mem_addr, bus.mem_wdata, bus.busy);
        else n_pass++;
        do_ack(8'h00);
        do_ack(8'hFF);
        n_total++;
        if ({bus.mem_req, bus.rd_valid, bus.busy, bus.out_data} !== {3'b000, 8'h3C})
            $display("FAIL idle_ack got req=%b rv=%b busy=%b data=%h want 0 0 0 3c",
                     bus.mem_req, bus.rd_valid, bus.busy, bus.out_data);
        else n_pass++;
        do_rd(8'h06);
        n_total++;
        if ({bus.mem_req, bus.miss_cnt} !== {1'b1, 16'd5})
            $display("FAIL no_alloc got req=%b miss=%0d want 1 5", bus.mem_req, bus.miss_cnt);
        else n_pass++;
        do_ack(8'h11);
        tick();
    endtask

    task automatic test_reset_mid();
        do_rd(8'h0D);
        #2 rst = 1'b0;
        #1;
        n_total++;
        if ({bus.mem_req, bus.busy, bus.rd_valid, bus.hit_cnt, bus.miss_cnt} !== {3'b000, 32'd0})
            $display("FAIL rst_async got req=%b busy=%b rv=%b hit=%0d miss=%0d want 0 0 0 0 0",
                     bus.mem_req, bus.busy, bus.rd_valid, bus.hit_cnt, bus.miss_cnt);
        else n_pass++;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 8'h99;
        tick();
        n_total++;
        if ({bus.rd_valid, bus.mem_req, bus.out_data} !== {2'b00, 8'h00})
            $display("FAIL rst_no_resp got rv=%b req=%b data=%h want 0 0 00", bus.rd_valid, bus.mem_req, bus.out_data);
        else n_pass++;
        bus.mem_ack = 1'b0;
        #2 rst = 1'b1;
        tick();
        do_rd(8'h0D);
        n_total++;
        if ({bus.mem_req, bus.rd_valid, bus.miss_cnt, bus.hit_cnt} !== {2'b10, 16'd1, 16'd0})
            $display("FAIL rst_no_fill got req=%b rv=%b miss=%0d hit=%0d want 1 0 1 0",
                     bus.mem_req, bus.rd_valid, bus.miss_cnt, bus.hit_cnt);
        else n_pass++;
        do_ack(8'h42);
        tick();
    endtask

    task automatic test_saturation();
        bus.rd_en = 1'b1;
        bus.addr  = 8'h0D;
        for (int i = 0; i < 65535; i++) tick();
        n_total++;
        if (bus.hit_cnt !== 16'hFFFF)
            $display("FAIL sat_reach got %h want ffff", bus.hit_cnt);
        else n_pass++;
        tick();
        tick();
        bus.rd_en = 1'b0;
        n_total++;
        if ({bus.hit_cnt, bus.rd_valid, bus.out_data} !== {16'hFFFF, 1'b1, 8'h42})
            $display("FAIL sat_hold got hit=%h rv=%b data=%h want ffff 1 42", bus.hit_cnt, bus.rd_valid, bus.out_data);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_read_miss();
        test_read_hit();
        test_write();
        test_alias();
        test_flush();
        test_priority_busy();
        test_reset_mid();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/cpu_cache_dm.md
CPU_CACHE_DM -- requirements
Module: cpu_cache_dm

Parameters
REQ-001 The block SHALL have parameter ADDR_W, default 8, CPU byte/word address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, data word width.
REQ-003 The block SHALL have parameter IDX_W, default 2, index width, giving 2**IDX_W lines of one word each; TAG_W = ADDR_W-IDX_W; IDX_W < ADDR_W required.

Interface
REQ-004 The block SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port rd_en, input, 1, CPU read request.
REQ-007 The block SHALL have port wr_en, input, 1, CPU write request.
REQ-008 The block SHALL have port flush, input, 1, invalidate all lines.
REQ-009 The block SHALL have port addr, input, ADDR_W, CPU address; index = addr[IDX_W-1:0], tag = upper bits.
REQ-010 The block SHALL have port data, input, DATA_W, CPU write data.
REQ-011 The block SHALL have port out_data, output, DATA_W, read data, valid when rd_valid=1.
REQ-012 The block SHALL have port rd_valid, output, 1, one-cycle read-complete pulse.
REQ-013 The block SHALL have port busy, output, 1, high when not in IDLE; requests ignored.
REQ-014 The block SHALL have ports mem_req (out 1), mem_we (out 1), mem_addr (out ADDR_W), mem_wdata (out DATA_W), mem_ack (in 1), mem_rdata (in DATA_W): backing-memory request/acknowledge.
REQ-015 The block SHALL have ports hit_cnt and miss_cnt, output, 16 each, saturating read hit/miss counters.

Function
REQ-016 FSM states SHALL be IDLE, MEM_RD, MEM_WR, RESP; busy = (state != IDLE), registered.
REQ-017 A request SHALL be accepted only on a clk edge in IDLE; addr/data latched at acceptance.
REQ-018 Priority in IDLE SHALL be flush > wr_en > rd_en; lower-priority requests same cycle are dropped.
REQ-019 Flush SHALL clear all valid bits at that edge; tags/data untouched; no memory traffic.
REQ-020 Read hit (valid && tag match): next cycle rd_valid=1, out_data=line data, hit_cnt+1, state stays IDLE (1-cycle latency, back-to-back hits allowed).
REQ-021 Read miss: miss_cnt+1, go MEM_RD; mem_req=1, mem_we=0, mem_addr=latched addr held stable until mem_ack.
REQ-022 On mem_ack in MEM_RD: line filled (valid=1, tag, data=mem_rdata), go RESP; RESP drives rd_valid=1, out_data=fill data for one cycle, then IDLE.
REQ-023 Write (write-through, no-allocate): on write hit, line data updated at acceptance edge; hit or miss, go MEM_WR with mem_req=1, mem_we=1, mem_addr/mem_wdata=latched values until mem_ack, then IDLE; counters unchanged.
REQ-024 mem_req SHALL deassert the cycle after mem_ack is sampled; mem_ack outside MEM_RD/MEM_WR SHALL be ignored.
REQ-025 out_data SHALL hold last value when rd_valid=0; rd_valid never high two cycles from one request.
REQ-026 Counters SHALL saturate at 16'hFFFF, no wrap.
REQ-027 Index aliasing: a miss fill SHALL overwrite the resident line regardless of its tag.

Reset
REQ-028 rst low SHALL asynchronously force: state IDLE, all valid bits 0, out_data 0, rd_valid 0, busy 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, hit_cnt 0, miss_cnt 0.
REQ-029 Reset mid-transaction SHALL abandon it immediately (mem_req drops, no fill, no rd_valid); data array contents need not reset.

Verification
REQ-030 After reset, read 0x05 -> miss_cnt=1, mem_req with mem_addr=0x05; ack with 0xA5 -> next cycle rd_valid=1, out_data=0xA5.
REQ-031 Read 0x05 again -> next cycle rd_valid=1, out_data=0xA5, hit_cnt=1, no mem_req.
REQ-032 Write 0x05=0x3C -> mem_req/mem_we with mem_addr=0x05, mem_wdata=0x3C, busy until ack; then read 0x05 hits with 0x3C. Write miss to 0x09 leaves line 1 unchanged.
REQ-033 Read 0x09 (same index 1, different tag) -> miss, fill 0x77; read 0x05 then misses again.
REQ-034 Flush, then read 0x09 -> miss; rd_en+wr_en together -> write only; requests while busy=1 -> no effect.
REQ-035 Assert rst while in MEM_RD awaiting ack -> mem_req=0 same cycle, no rd_valid, line remains invalid, counters 0.
